// File: rtl/ysyx_210544_reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate issue on
// RAW hazards and on WAW counter overflow, retired by the writeback port.
module ysyx_210544_reg_scoreboard #(
  parameter int PEND_W    = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_issue_valid,
  output logic        o_issue_ready,
  input  logic [4:0]  i_rs1,
  input  logic        i_rs1_ren,
  input  logic [4:0]  i_rs2,
  input  logic        i_rs2_ren,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_wen,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_flush,
  output logic [31:0] o_busy,
  output logic [31:0] o_stall_cnt,
  output logic        o_err
);

  localparam logic [PEND_W-1:0] CNT_ZERO = '0;
  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};

  logic [PEND_W-1:0] cnt_q [32];
  logic [PEND_W-1:0] cnt_d [32];
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;
  logic [PEND_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
  logic              raw1, raw2, waw, ready, fire;
  logic [31:0]       inc_v, dec_v;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Hazard detection against the registered pending counts
  always_comb begin
    rs1_cnt = cnt_q[i_rs1];
    rs2_cnt = cnt_q[i_rs2];
    rd_cnt  = cnt_q[i_rd];
    wb_cnt  = cnt_q[i_wb_rd];
    raw1 = i_rs1_ren && (i_rs1 != 5'd0) && (rs1_cnt != CNT_ZERO) &&
           !(WB_BYPASS && i_wb_valid && (i_wb_rd == i_rs1) && (rs1_cnt == CNT_ONE));
    raw2 = i_rs2_ren && (i_rs2 != 5'd0) && (rs2_cnt != CNT_ZERO) &&
           !(WB_BYPASS && i_wb_valid && (i_wb_rd == i_rs2) && (rs2_cnt == CNT_ONE));
    // A retiring write to rd frees one slot, so a full counter can still accept
    waw  = i_rd_wen && (i_rd != 5'd0) && (rd_cnt == CNT_MAX) &&
           !(i_wb_valid && (i_wb_rd == i_rd));
    ready = !rst && !i_flush && !raw1 && !raw2 && !waw;
    fire  = i_issue_valid && ready;
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < 32; r++) begin
      inc_v[r] = fire && i_rd_wen && (i_rd == 5'(r));
      dec_v[r] = i_wb_valid && (i_wb_rd == 5'(r)) && (cnt_q[r] != CNT_ZERO);
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0 || i_flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (inc_v[r] && !dec_v[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    err_d = err_q ||
            (i_wb_valid && (i_wb_rd != 5'd0) && (wb_cnt == CNT_ZERO) && !i_flush);
    stall_cnt_d = (i_issue_valid && !ready && !rst) ? sat_inc32(stall_cnt_q)
                                                    : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= CNT_ZERO;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    o_busy[0] = 1'b0;
    for (int r = 1; r < 32; r++) o_busy[r] = (cnt_q[r] != CNT_ZERO);
  end

  assign o_issue_ready = ready;
  assign o_stall_cnt   = stall_cnt_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_ysyx_210544_reg_scoreboard.sv
// Bench for the register scoreboard: directed scenarios plus randomized traffic
// checked against a pending-count model of the hazard rules.
module tb_ysyx_210544_reg_scoreboard;

  localparam int PEND_W    = 2;
  localparam bit WB_BYPASS = 1'b1;
  localparam int MAXC      = (1 << PEND_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_issue_valid;
  logic        o_issue_ready;
  logic [4:0]  i_rs1, i_rs2, i_rd, i_wb_rd;
  logic        i_rs1_ren, i_rs2_ren, i_rd_wen, i_wb_valid, i_flush;
  logic [31:0] o_busy, o_stall_cnt;
  logic        o_err;

  int          n_pass  = 0;
  int          n_total = 0;

  int          mcnt [32];
  logic        merr;
  logic [31:0] mstall;

  ysyx_210544_reg_scoreboard #(.PEND_W(PEND_W), .WB_BYPASS(WB_BYPASS)) dut (
    .clk(clk), .rst(rst), .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
    .i_rs1(i_rs1), .i_rs1_ren(i_rs1_ren), .i_rs2(i_rs2), .i_rs2_ren(i_rs2_ren),
    .i_rd(i_rd), .i_rd_wen(i_rd_wen), .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd),
    .i_flush(i_flush), .o_busy(o_busy), .o_stall_cnt(o_stall_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  function automatic bit model_ready();
    bit raw1, raw2, waw;
    if (rst || i_flush) return 1'b0;
    raw1 = i_rs1_ren && i_rs1 != 0 && mcnt[i_rs1] > 0 &&
           !(WB_BYPASS && i_wb_valid && i_wb_rd == i_rs1 && mcnt[i_rs1] == 1);
    raw2 = i_rs2_ren && i_rs2 != 0 && mcnt[i_rs2] > 0 &&
           !(WB_BYPASS && i_wb_valid && i_wb_rd == i_rs2 && mcnt[i_rs2] == 1);
    waw  = i_rd_wen && i_rd != 0 && mcnt[i_rd] == MAXC &&
           !(i_wb_valid && i_wb_rd == i_rd);
    return !(raw1 || raw2 || waw);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic set_idle();
    rst = 1'b0; i_issue_valid = 1'b0; i_flush = 1'b0;
    i_rs1 = '0; i_rs1_ren = 1'b0; i_rs2 = '0; i_rs2_ren = 1'b0;
    i_rd = '0; i_rd_wen = 1'b0; i_wb_valid = 1'b0; i_wb_rd = '0;
  endtask

  // Advance one clock edge, updating the model with the inputs held across it
  task automatic cycle();
    bit rdy;
    rdy = model_ready();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      merr = 1'b0;
      mstall = '0;
    end else begin
      if (i_issue_valid && !rdy && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
      if (i_flush) begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
      end else begin
        if (i_wb_valid && i_wb_rd != 0) begin
          if (mcnt[i_wb_rd] == 0) merr = 1'b1;
          else mcnt[i_wb_rd] = mcnt[i_wb_rd] - 1;
        end
        if (i_issue_valid && rdy && i_rd_wen && i_rd != 0) mcnt[i_rd] = mcnt[i_rd] + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; i_issue_valid = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_issue_ready);
    else n_pass++;
    cycle(); cycle();
    set_idle();
    #1;
    n_total++;
    if (o_busy !== 32'h0) $display("FAIL reset_busy: got %h want 0", o_busy); else n_pass++;
    n_total++;
    if (o_stall_cnt !== 32'h0) $display("FAIL reset_stall: got %0d want 0", o_stall_cnt); else n_pass++;
    n_total++;
    if (o_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_err); else n_pass++;
  endtask

  task automatic test_raw();
    set_idle();
    i_issue_valid = 1'b1; i_rd = 5'd5; i_rd_wen = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL raw_first_issue: got %b want 1", o_issue_ready); else n_pass++;
    cycle();
    i_rd_wen = 1'b0; i_rd = 5'd0; i_rs1 = 5'd5; i_rs1_ren = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b0) $display("FAIL raw_stall_ready: got %b want 0", o_issue_ready); else n_pass++;
    n_total++;
    if (o_busy[5] !== 1'b1) $display("FAIL raw_busy5: got %b want 1", o_busy[5]); else n_pass++;
    cycle(); cycle(); cycle();
    n_total++;
    if (o_stall_cnt !== 32'd3 || o_stall_cnt !== mstall)
      $display("FAIL raw_stall_cnt: got %0d want 3", o_stall_cnt);
    else n_pass++;
    i_wb_valid = 1'b1; i_wb_rd = 5'd5;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL raw_bypass_ready: got %b want 1", o_issue_ready); else n_pass++;
    cycle();
    set_idle();
    #1;
    n_total++;
    if (o_busy[5] !== 1'b0) $display("FAIL raw_busy5_clear: got %b want 0", o_busy[5]); else n_pass++;
  endtask

  task automatic test_x0();
    set_idle();
    i_issue_valid = 1'b1; i_rd = 5'd0; i_rd_wen = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL x0_rd_ready: got %b want 1", o_issue_ready); else n_pass++;
    cycle();
    i_rd_wen = 1'b0; i_rs1_ren = 1'b1; i_rs2_ren = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL x0_src_ready: got %b want 1", o_issue_ready); else n_pass++;
    n_total++;
    if (o_busy !== 32'h0) $display("FAIL x0_busy: got %h want 0", o_busy); else n_pass++;
    cycle();
    set_idle();
    i_wb_valid = 1'b1; i_wb_rd = 5'd0;
    cycle();
    set_idle();
    n_total++;
    if (o_err !== 1'b0) $display("FAIL x0_wb_err: got %b want 0", o_err); else n_pass++;
  endtask

  task automatic test_waw();
    set_idle();
    i_issue_valid = 1'b1; i_rd = 5'd7; i_rd_wen = 1'b1;
    for (int k = 0; k < MAXC; k++) begin
      #1;
      n_total++;
      if (o_issue_ready !== 1'b1) $display("FAIL waw_fill_%0d: got %b want 1", k, o_issue_ready); else n_pass++;
      cycle();
    end
    #1;
    n_total++;
    if (o_issue_ready !== 1'b0) $display("FAIL waw_full_ready: got %b want 0", o_issue_ready); else n_pass++;
    i_wb_valid = 1'b1; i_wb_rd = 5'd7;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL waw_wb_ready: got %b want 1", o_issue_ready); else n_pass++;
    cycle();
    // Drain: busy must persist until the third retire if the count stayed full
    set_idle();
    i_wb_valid = 1'b1; i_wb_rd = 5'd7;
    for (int k = 0; k < MAXC; k++) begin
      cycle();
      n_total++;
      if (o_busy[7] !== ((k < MAXC - 1) ? 1'b1 : 1'b0))
        $display("FAIL waw_drain_%0d: got %b want %b", k, o_busy[7], (k < MAXC - 1));
      else n_pass++;
    end
    set_idle();
    n_total++;
    if (o_err !== 1'b0) $display("FAIL waw_err: got %b want 0", o_err); else n_pass++;
  endtask

  task automatic test_same_rd();
    set_idle();
    i_issue_valid = 1'b1; i_rd = 5'd9; i_rd_wen = 1'b1;
    cycle();
    i_wb_valid = 1'b1; i_wb_rd = 5'd9;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b1) $display("FAIL same_rd_ready: got %b want 1", o_issue_ready); else n_pass++;
    cycle();
    n_total++;
    if (o_busy[9] !== 1'b1) $display("FAIL same_rd_busy: got %b want 1", o_busy[9]); else n_pass++;
    set_idle();
    i_wb_valid = 1'b1; i_wb_rd = 5'd9;
    cycle();
    set_idle();
    n_total++;
    if (o_busy[9] !== 1'b0 || o_err !== 1'b0)
      $display("FAIL same_rd_drain: got busy=%b err=%b want busy=0 err=0", o_busy[9], o_err);
    else n_pass++;
  endtask

  task automatic test_flush();
    set_idle();
    i_issue_valid = 1'b1; i_rd_wen = 1'b1; i_rd = 5'd3;
    cycle();
    i_rd = 5'd4;
    cycle();
    n_total++;
    if (o_busy !== 32'h18) $display("FAIL flush_pre_busy: got %h want 00000018", o_busy); else n_pass++;
    i_flush = 1'b1; i_rd = 5'd3; i_wb_valid = 1'b1; i_wb_rd = 5'd3;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", o_issue_ready); else n_pass++;
    cycle();
    set_idle();
    #1;
    n_total++;
    if (o_busy !== 32'h0) $display("FAIL flush_busy: got %h want 0", o_busy); else n_pass++;
    n_total++;
    if (o_err !== 1'b0) $display("FAIL flush_err: got %b want 0", o_err); else n_pass++;
    i_wb_valid = 1'b1; i_wb_rd = 5'd4;
    cycle();
    set_idle();
    n_total++;
    if (o_err !== 1'b1) $display("FAIL flush_late_wb_err: got %b want 1", o_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int budget;
    set_idle();
    i_issue_valid = 1'b1; i_rd = 5'd6; i_rd_wen = 1'b1;
    cycle();
    i_rd_wen = 1'b0; i_rs1 = 5'd6; i_rs1_ren = 1'b1;
    budget = 0;
    while (mstall < 32'd10 && budget < 50) begin
      cycle();
      budget++;
    end
    n_total++;
    if (o_stall_cnt !== 32'd10) $display("FAIL mid_stall_cnt: got %0d want 10", o_stall_cnt); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (o_issue_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", o_issue_ready); else n_pass++;
    cycle();
    set_idle();
    #1;
    n_total++;
    if (o_busy !== 32'h0 || o_stall_cnt !== 32'h0 || o_err !== 1'b0)
      $display("FAIL mid_rst_state: got busy=%h stall=%0d err=%b want 0/0/0", o_busy, o_stall_cnt, o_err);
    else n_pass++;
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int n = 0; n < 400; n++) begin
      set_idle();
      rst           = ($urandom_range(0, 63) == 0);
      i_flush       = ($urandom_range(0, 31) == 0);
      i_issue_valid = 1'($urandom_range(0, 1));
      i_rs1         = 5'($urandom_range(0, 7));
      i_rs1_ren     = 1'($urandom_range(0, 1));
      i_rs2         = 5'($urandom_range(0, 7));
      i_rs2_ren     = 1'($urandom_range(0, 1));
      i_rd          = 5'($urandom_range(0, 7));
      i_rd_wen      = 1'($urandom_range(0, 1));
      i_wb_rd       = 5'($urandom_range(0, 7));
      i_wb_valid    = ($urandom_range(0, 1) == 1) &&
                      (mcnt[i_wb_rd] > 0 || $urandom_range(0, 15) == 0);
      #1;
      exp_rdy = model_ready();
      n_total++;
      if (o_issue_ready !== exp_rdy)
        $display("FAIL rand_ready[%0d]: got %b want %b", n, o_issue_ready, exp_rdy);
      else n_pass++;
      cycle();
      n_total++;
      if (o_busy !== model_busy())
        $display("FAIL rand_busy[%0d]: got %h want %h", n, o_busy, model_busy());
      else n_pass++;
      n_total++;
      if (o_stall_cnt !== mstall)
        $display("FAIL rand_stall[%0d]: got %0d want %0d", n, o_stall_cnt, mstall);
      else n_pass++;
      n_total++;
      if (o_err !== merr) $display("FAIL rand_err[%0d]: got %b want %b", n, o_err, merr);
      else n_pass++;
    end
    set_idle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
    mstall = '0;
    set_idle();
    test_reset();
    test_raw();
    test_x0();
    test_waw();
    test_same_rd();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
